sensor_conditioner: RTL and testbench
=====================================

Name: sensor_conditioner

Overview:
- Conditions the three raw line sensors before they reach the controller. Each input passes through a two-flop synchronizer and a per-channel stability debouncer.
- Publishes the filtered sensor levels, a 3-bit pattern, a pattern-change strobe, a crossing strobe and a line-lost flag.
- Sits between the sensor pins and the controller, in the input-buffer position of the robot top level.
- Sensor convention: 1 = black line under sensor.

Parameters:
- DEBOUNCE_CYCLES, 1000, consecutive cycles a synchronized input must differ from the filtered value before the filtered value updates (min 1).
- LOST_CYCLES, 2000000, consecutive cycles of filtered pattern 000 before line_lost asserts (one 20 ms timebase period at 100 MHz; min 1).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- sensor_l_in  input  1  raw left sensor, asynchronous to clk
- sensor_m_in  input  1  raw middle sensor, asynchronous to clk
- sensor_r_in  input  1  raw right sensor, asynchronous to clk
- sensor_l  output  1  filtered left level
- sensor_m  output  1  filtered middle level
- sensor_r  output  1  filtered right level
- pattern  output  3  {sensor_l, sensor_m, sensor_r}
- pattern_change  output  1  one-cycle strobe when pattern takes a new value
- crossing  output  1  one-cycle strobe when pattern enters 111
- line_lost  output  1  level: pattern has been 000 for at least LOST_CYCLES cycles

Behaviour:
- Reset (reset=0, asynchronous): synchronizer flops, filtered levels, debounce counters, lost counter, pattern_change, crossing and line_lost all clear to 0 immediately. This holds mid-count as well; no partial state survives.
- Synchronizer: two flops per channel. The synchronized value lags the pin by 2 cycles.
- Debounce, independent per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
  - sync == filtered: counter <= 0.
  - sync != filtered and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync != filtered and counter == DEBOUNCE_CYCLES-1: filtered <= sync, counter <= 0.
- A clean pin edge held stable is visible on sensor_x exactly DEBOUNCE_CYCLES+2 cycles after the edge is sampled.
- A pulse shorter than DEBOUNCE_CYCLES synchronized cycles is discarded and its counter returns to 0.
- pattern_change is registered. It is high for exactly the one cycle in which the new filtered pattern first appears on the outputs.
- If two or three channels update on the same edge, there is a single pattern_change pulse.
- crossing is high for exactly the first cycle pattern == 111 after any non-111 pattern. There is no repeat pulse while 111 is held. The 111 state present right after reset does not count, because pattern resets to 000.
- Lost counter:
  - Width $clog2(LOST_CYCLES+1).
  - Increments each cycle pattern == 000 and saturates at LOST_CYCLES.
  - Clears to 0 on the edge where the next filtered pattern is non-zero.
- line_lost:
  - Rises on the edge where the counter reaches LOST_CYCLES.
  - Falls on the same edge the filtered pattern becomes non-zero, with zero extra latency relative to pattern.
- After reset the pattern is 000, so line_lost asserts LOST_CYCLES cycles after reset release unless a sensor sees the line first.
- Counters never wrap. Outputs are glitch-free registers.

Decomposition:
- Package sensor_pkg:
  - typedef sensor_pattern_t (logic [2:0]).
  - Constants PAT_LOST = 3'b000 and PAT_CROSS = 3'b111.
  - Default values of DEBOUNCE_CYCLES and LOST_CYCLES.
- Sub-module debounce_channel (synchronizer + debounce counter, parameter DEBOUNCE_CYCLES, output filtered and a one-cycle updated flag), instantiated three times.
- The top of the block owns the pattern, strobe and lost logic.

Test Plan (bench uses DEBOUNCE_CYCLES=4, LOST_CYCLES=16):
- Reset released with all inputs 0 -> all outputs 0; line_lost rises exactly 16 cycles after the first clock edge with reset=1.
- sensor_m_in 0->1, held -> sensor_m=1 and pattern=010 exactly 6 cycles after the sampling edge; pattern_change high for that cycle only; line_lost drops on the same edge.
- sensor_l_in pulsed high for 3 cycles then low -> sensor_l stays 0, pattern_change never asserts, left debounce counter back at 0.
- All three inputs driven 1 on the same edge, held -> pattern 000->111 in one step; exactly one pattern_change and one crossing pulse, on the same cycle; holding 10 more cycles gives no further pulses.
- From pattern 010, drop sensor_m_in to 0 -> pattern=000 after 6 cycles; line_lost asserts 16 cycles later; re-raising sensor_r_in clears line_lost on the edge pattern becomes 001.
- Assert reset mid-debounce (counter at 2) and mid-lost-count -> all outputs 0 immediately without a clock edge; after release, a held input still needs the full 6 cycles to appear.

Source files
------------

// File: rtl/sensor_pkg.sv
// -----------------------------------------------------------------------------
// sensor_pkg
// Shared types and constants for the line-sensor input conditioner.
//   sensor_pattern_t : {left, middle, right} filtered sensor levels (1 = line)
//   PAT_LOST         : no sensor sees the line
//   PAT_CROSS        : all sensors see the line (cross track)
//   *_DEF            : default timing parameters (100 MHz system clock)
// -----------------------------------------------------------------------------
package sensor_pkg;

    typedef logic [2:0] sensor_pattern_t;

    localparam sensor_pattern_t PAT_LOST  = 3'b000;
    localparam sensor_pattern_t PAT_CROSS = 3'b111;

    // 10 us of stable input before a level is accepted
    localparam int DEBOUNCE_CYCLES_DEF = 1000;
    // 20 ms of an empty pattern before the line is declared lost
    localparam int LOST_CYCLES_DEF     = 2000000;

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One sensor input: two-flop synchronizer followed by a stability debouncer.
// The filtered level only follows the synchronized input after it has
// differed from the filtered level for DEBOUNCE_CYCLES consecutive cycles.
//
// Ports
//   clk      : system clock
//   reset    : asynchronous active-low reset
//   pin      : raw sensor input, asynchronous to clk
//   filtered : debounced level (register)
//   updated  : high in the cycle whose closing edge loads filtered with the
//              new level, so filtered ^ updated is the next filtered value
// -----------------------------------------------------------------------------
module debounce_channel
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic filtered,
    output logic updated
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] count;

    // Exposed combinationally so the top can see the next filtered pattern
    // one cycle early and register its strobes in step with the levels.
    assign updated = (sync != filtered) && (count == COUNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta     <= 1'b0;
            sync     <= 1'b0;
            filtered <= 1'b0;
            count    <= '0;
        end else begin
            meta <= pin;
            sync <= meta;
            if (sync == filtered) begin
                // any agreement restarts the stability window
                count <= '0;
            end else if (updated) begin
                filtered <= sync;
                count    <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// -----------------------------------------------------------------------------
// sensor_conditioner
// Input buffer between the three line-sensor pins and the controller.
// Each pin is synchronized and debounced; this level derives the pattern,
// the pattern-change and crossing strobes, and the line-lost flag.
//
// Ports
//   clk            : system clock, all state on rising edge
//   reset          : asynchronous active-low reset
//   sensor_l_in    : raw left sensor (asynchronous)
//   sensor_m_in    : raw middle sensor (asynchronous)
//   sensor_r_in    : raw right sensor (asynchronous)
//   sensor_l/m/r   : filtered levels (1 = line under sensor)
//   pattern        : {sensor_l, sensor_m, sensor_r}
//   pattern_change : one-cycle strobe in the first cycle of a new pattern
//   crossing       : one-cycle strobe in the first cycle of pattern 111
//   line_lost      : pattern has been 000 for at least LOST_CYCLES cycles
// -----------------------------------------------------------------------------
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LOST_CYCLES     = LOST_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            sensor_l_in,
    input  logic            sensor_m_in,
    input  logic            sensor_r_in,
    output logic            sensor_l,
    output logic            sensor_m,
    output logic            sensor_r,
    output sensor_pattern_t pattern,
    output logic            pattern_change,
    output logic            crossing,
    output logic            line_lost
);

    localparam int LW = $clog2(LOST_CYCLES + 1);
    localparam logic [LW-1:0] LOST_MAX = LW'(LOST_CYCLES);
    localparam logic [LW-1:0] LOST_PRE = LW'(LOST_CYCLES - 1);

    logic            upd_l;
    logic            upd_m;
    logic            upd_r;
    sensor_pattern_t pattern_next;
    logic [LW-1:0]   lost_cnt;

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_l (
        .clk      (clk),
        .reset    (reset),
        .pin      (sensor_l_in),
        .filtered (sensor_l),
        .updated  (upd_l)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_m (
        .clk      (clk),
        .reset    (reset),
        .pin      (sensor_m_in),
        .filtered (sensor_m),
        .updated  (upd_m)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan_r (
        .clk      (clk),
        .reset    (reset),
        .pin      (sensor_r_in),
        .filtered (sensor_r),
        .updated  (upd_r)
    );

    assign pattern = {sensor_l, sensor_m, sensor_r};

    // Pattern that will be on the outputs after the coming edge. Deciding
    // strobes and line_lost from it lets them change on the same edge as
    // the filtered levels, with no extra latency.
    assign pattern_next = pattern ^ {upd_l, upd_m, upd_r};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pattern_change <= 1'b0;
            crossing       <= 1'b0;
            line_lost      <= 1'b0;
            lost_cnt       <= '0;
        end else begin
            // simultaneous channel updates collapse into a single strobe
            pattern_change <= (pattern_next != pattern);
            crossing       <= (pattern_next == PAT_CROSS) && (pattern != PAT_CROSS);

            if (pattern_next != PAT_LOST) begin
                lost_cnt  <= '0;
                line_lost <= 1'b0;
            end else if (pattern == PAT_LOST) begin
                if (lost_cnt != LOST_MAX) begin
                    lost_cnt <= lost_cnt + 1'b1;
                end
                if (lost_cnt >= LOST_PRE) begin
                    line_lost <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sensor_conditioner.sv
// -----------------------------------------------------------------------------
// tb_sensor_conditioner
// Directed bench for sensor_conditioner with DEBOUNCE_CYCLES=4, LOST_CYCLES=16.
// Inputs change 1 ns after a rising edge, so the next rising edge is the
// sampling edge; a held edge shows on the filtered output after the 6th
// rising edge counted from (and including) the sampling edge.
// -----------------------------------------------------------------------------
module tb_sensor_conditioner;
    import sensor_pkg::*;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            l_in = 1'b0;
    logic            m_in = 1'b0;
    logic            r_in = 1'b0;
    logic            sensor_l;
    logic            sensor_m;
    logic            sensor_r;
    sensor_pattern_t pattern;
    logic            pattern_change;
    logic            crossing;
    logic            line_lost;

    int n_checks = 0;
    int n_pass   = 0;
    int pc_cnt   = 0;
    int cr_cnt   = 0;

    sensor_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .LOST_CYCLES    (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .sensor_l_in    (l_in),
        .sensor_m_in    (m_in),
        .sensor_r_in    (r_in),
        .sensor_l       (sensor_l),
        .sensor_m       (sensor_m),
        .sensor_r       (sensor_r),
        .pattern        (pattern),
        .pattern_change (pattern_change),
        .crossing       (crossing),
        .line_lost      (line_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (pattern_change) pc_cnt++;
        if (crossing) cr_cnt++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset asserted asynchronously before any clock edge
        #2 reset = 1'b0;
        #1;
        check("rst_levels",  {29'd0, sensor_l, sensor_m, sensor_r}, 32'd0);
        check("rst_pattern", {29'd0, pattern}, 32'd0);
        check("rst_strobes", {30'd0, pattern_change, crossing}, 32'd0);
        check("rst_lost",    {31'd0, line_lost}, 32'd0);

        // release; line_lost after the 16th edge with reset high
        @(posedge clk);
        #1 reset = 1'b1;
        pc_cnt = 0;
        cr_cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 15) check("lost_k15", {31'd0, line_lost}, 32'd0);
            if (k == 16) check("lost_k16", {31'd0, line_lost}, 32'd1);
        end
        check("idle_no_pc", pc_cnt, 32'd0);

        // middle rises
        m_in = 1'b1;
        pc_cnt = 0;
        ticks(5);
        check("m_e5_level", {31'd0, sensor_m}, 32'd0);
        check("m_e5_lost",  {31'd0, line_lost}, 32'd1);
        tick();
        check("m_e6_level",   {31'd0, sensor_m}, 32'd1);
        check("m_e6_pattern", {29'd0, pattern}, 32'b010);
        check("m_e6_pc",      {31'd0, pattern_change}, 32'd1);
        check("m_e6_lost",    {31'd0, line_lost}, 32'd0);
        tick();
        check("m_e7_pc", {31'd0, pattern_change}, 32'd0);
        check("m_pc_count", pc_cnt, 32'd1);

        // 3-cycle glitch on left is rejected
        pc_cnt = 0;
        l_in = 1'b1;
        ticks(3);
        l_in = 1'b0;
        ticks(2);
        check("glitch_cnt_peak", {29'd0, dut.u_chan_l.count}, 32'd3);
        tick();
        check("glitch_cnt_zero", {29'd0, dut.u_chan_l.count}, 32'd0);
        ticks(4);
        check("glitch_level",   {31'd0, sensor_l}, 32'd0);
        check("glitch_pattern", {29'd0, pattern}, 32'b010);
        check("glitch_no_pc",   pc_cnt, 32'd0);

        // middle falls: 000, then line_lost after 16 more edges
        m_in = 1'b0;
        ticks(5);
        check("mf_e5_pattern", {29'd0, pattern}, 32'b010);
        tick();
        check("mf_e6_pattern", {29'd0, pattern}, 32'b000);
        check("mf_e6_pc",      {31'd0, pattern_change}, 32'd1);
        ticks(15);
        check("mf_lost_15", {31'd0, line_lost}, 32'd0);
        tick();
        check("mf_lost_16", {31'd0, line_lost}, 32'd1);
        ticks(4);
        check("lost_saturate", {27'd0, dut.lost_cnt}, 32'd16);
        check("lost_held",     {31'd0, line_lost}, 32'd1);

        // right rises: line_lost clears with the pattern
        r_in = 1'b1;
        ticks(5);
        check("r_e5_lost", {31'd0, line_lost}, 32'd1);
        tick();
        check("r_e6_pattern", {29'd0, pattern}, 32'b001);
        check("r_e6_lost",    {31'd0, line_lost}, 32'd0);

        // back to 000, then all three at once
        r_in = 1'b0;
        ticks(6);
        check("pre_x_pattern", {29'd0, pattern}, 32'b000);
        l_in = 1'b1;
        m_in = 1'b1;
        r_in = 1'b1;
        pc_cnt = 0;
        cr_cnt = 0;
        ticks(5);
        check("x_e5_pattern", {29'd0, pattern}, 32'b000);
        tick();
        check("x_e6_pattern",  {29'd0, pattern}, 32'b111);
        check("x_e6_pc",       {31'd0, pattern_change}, 32'd1);
        check("x_e6_crossing", {31'd0, crossing}, 32'd1);
        ticks(10);
        check("x_pc_count", pc_cnt, 32'd1);
        check("x_cr_count", cr_cnt, 32'd1);
        check("x_held",     {29'd0, pattern}, 32'b111);

        // drop all, then reset mid-debounce and mid-lost-count
        l_in = 1'b0;
        m_in = 1'b0;
        r_in = 1'b0;
        cr_cnt = 0;
        ticks(6);
        check("drop_pattern", {29'd0, pattern}, 32'b000);
        check("drop_no_cross", cr_cnt, 32'd0);
        ticks(4);
        l_in = 1'b1;
        ticks(4);
        check("mid_deb_cnt",  {29'd0, dut.u_chan_l.count}, 32'd2);
        check("mid_lost_cnt", {27'd0, dut.lost_cnt}, 32'd8);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_deb_cnt",  {29'd0, dut.u_chan_l.count}, 32'd0);
        check("mid_rst_lost_cnt", {27'd0, dut.lost_cnt}, 32'd0);
        check("mid_rst_outs", {23'd0, sensor_l, sensor_m, sensor_r, pattern,
                               pattern_change, crossing, line_lost}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        pc_cnt = 0;
        ticks(5);
        check("post_rst_e5", {31'd0, sensor_l}, 32'd0);
        tick();
        check("post_rst_e6",      {31'd0, sensor_l}, 32'd1);
        check("post_rst_pattern", {29'd0, pattern}, 32'b100);
        check("post_rst_pc",      pc_cnt, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
